reg_ctrl: RTL

- Sequencing decoder that drives the write and read side of the 8×8 register file, the ALU selects and the data-memory handshake.
- Each 32-bit instruction is decoded into:
  - register addresses (`INADDRESS`, `OUT1ADDRESS`, `OUT2ADDRESS`);
  - an immediate;
  - ALU and mux selects;
  - exactly one `WRITE` pulse per register-writing instruction.
- Loads and stores are stalled on the data-memory `BUSYWAIT`.
- Sits between instruction fetch and the register file/ALU.

---
 rtl/reg_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/reg_ctrl.sv
// reg_ctrl: sequencing decoder between instruction fetch and the register
// file / ALU / data memory. A four-state FSM (FETCH, EXEC, MEM, WB) latches
// one instruction, drives registered controls, and stalls memory ops on
// BUSYWAIT. READY is the only combinational output.
module reg_ctrl (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        INSTR_VALID,
   input  logic        BUSYWAIT,
   output logic        READY,
   output logic [2:0]  INADDRESS,
   output logic [2:0]  OUT1ADDRESS,
   output logic [2:0]  OUT2ADDRESS,
   output logic        WRITE,
   output logic [7:0]  IMMEDIATE,
   output logic [2:0]  ALUOP,
   output logic        IMM_SEL,
   output logic        NEG_SEL,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        WB_SEL,
   output logic        JUMP,
   output logic        BRANCH,
   output logic        ILLEGAL
);

   typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   state_t      state, state_nxt;
   logic [31:0] ir;
   logic [31:0] dw;

   // decoded fields of the word in flight
   logic        use_rd, use_rs1, use_rs2, bad_op, illegal;
   logic        is_mem, is_load, reg_wr;
   logic [2:0]  d_aluop;
   logic        d_imm_sel, d_neg_sel, d_jump, d_branch, imm_hi;

   // next values of the registered outputs
   logic        drive_base;
   logic        n_write, n_mem_read, n_mem_write, n_wb_sel, n_illegal;

   assign READY = (state == FETCH);

   // Decode the incoming word while accepting, the latched word afterwards,
   // so INSTRUCTION changes outside FETCH have no effect.
   assign dw = (state == FETCH) ? INSTRUCTION : ir;

   // Opcode decode: which fields are registers, ALU setup, and op class
   always_comb begin
      use_rd    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      bad_op    = 1'b0;
      is_mem    = 1'b0;
      is_load   = 1'b0;
      reg_wr    = 1'b0;
      d_aluop   = ALU_FWD;
      d_imm_sel = 1'b0;
      d_neg_sel = 1'b0;
      d_jump    = 1'b0;
      d_branch  = 1'b0;
      imm_hi    = 1'b0;
      case (dw[31:24])
         8'd0:  begin use_rd = 1'b1; d_imm_sel = 1'b1; reg_wr = 1'b1; end
         8'd1:  begin use_rd = 1'b1; use_rs2 = 1'b1; reg_wr = 1'b1; end
         8'd2:  begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                      d_aluop = ALU_ADD; reg_wr = 1'b1; end
         8'd3:  begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                      d_aluop = ALU_ADD; d_neg_sel = 1'b1; reg_wr = 1'b1; end
         8'd4:  begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                      d_aluop = ALU_AND; reg_wr = 1'b1; end
         8'd5:  begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                      d_aluop = ALU_OR; reg_wr = 1'b1; end
         8'd6:  begin d_jump = 1'b1; imm_hi = 1'b1; end
         8'd7:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; d_aluop = ALU_ADD;
                      d_neg_sel = 1'b1; d_branch = 1'b1; imm_hi = 1'b1; end
         8'd8:  begin use_rd = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; is_load = 1'b1; end
         8'd9:  begin use_rd = 1'b1; d_imm_sel = 1'b1; is_mem = 1'b1; is_load = 1'b1; end
         8'd10: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; end
         8'd11: begin use_rs1 = 1'b1; d_imm_sel = 1'b1; is_mem = 1'b1; end
         default: bad_op = 1'b1;
      endcase
      illegal = bad_op
              | (use_rd  & (|dw[23:19]))
              | (use_rs1 & (|dw[15:11]))
              | (use_rs2 & (|dw[7:3]));
   end

   // Next state and next registered controls; anything not driven is 0
   always_comb begin
      state_nxt   = state;
      drive_base  = 1'b0;
      n_write     = 1'b0;
      n_mem_read  = 1'b0;
      n_mem_write = 1'b0;
      n_wb_sel    = 1'b0;
      n_illegal   = 1'b0;
      case (state)
         FETCH: begin
            if (INSTR_VALID) begin
               state_nxt = EXEC;
               if (illegal) begin
                  n_illegal = 1'b1;
               end else begin
                  drive_base = 1'b1;
                  n_write    = reg_wr;
               end
            end
         end
         EXEC: begin
            if (is_mem && !illegal) begin
               state_nxt   = MEM;
               drive_base  = 1'b1;
               n_mem_read  = is_load;
               n_mem_write = !is_load;
            end else begin
               state_nxt = FETCH;
            end
         end
         MEM: begin
            if (BUSYWAIT) begin
               drive_base  = 1'b1;
               n_mem_read  = is_load;
               n_mem_write = !is_load;
            end else if (is_load) begin
               state_nxt  = WB;
               drive_base = 1'b1;
               n_write    = 1'b1;
               n_wb_sel   = 1'b1;
            end else begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // State register and instruction latch
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= FETCH;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && INSTR_VALID) ir <= INSTRUCTION;
      end
   end

   // Registered control outputs; addresses/ALU setup only while driven
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         INADDRESS   <= '0;
         OUT1ADDRESS <= '0;
         OUT2ADDRESS <= '0;
         IMMEDIATE   <= '0;
         ALUOP       <= '0;
         IMM_SEL     <= 1'b0;
         NEG_SEL     <= 1'b0;
         JUMP        <= 1'b0;
         BRANCH      <= 1'b0;
         WRITE       <= 1'b0;
         MEM_READ    <= 1'b0;
         MEM_WRITE   <= 1'b0;
         WB_SEL      <= 1'b0;
         ILLEGAL     <= 1'b0;
      end else begin
         INADDRESS   <= drive_base ? dw[18:16] : 3'd0;
         OUT1ADDRESS <= drive_base ? dw[10:8]  : 3'd0;
         OUT2ADDRESS <= drive_base ? dw[2:0]   : 3'd0;
         IMMEDIATE   <= drive_base ? (imm_hi ? dw[23:16] : dw[7:0]) : 8'd0;
         ALUOP       <= drive_base ? d_aluop : ALU_FWD;
         IMM_SEL     <= drive_base & d_imm_sel;
         NEG_SEL     <= drive_base & d_neg_sel;
         JUMP        <= drive_base & d_jump;
         BRANCH      <= drive_base & d_branch;
         WRITE       <= n_write;
         MEM_READ    <= n_mem_read;
         MEM_WRITE   <= n_mem_write;
         WB_SEL      <= n_wb_sel;
         ILLEGAL     <= n_illegal;
      end
   end

endmodule
